// File: rtl/ndma_pkg.sv
// Shared types for the NDMA write manager: buffered write job and FSM state.
package ndma_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // One buffered destination write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } wr_entry_t;

    // Write-issue FSM: wait for work, present address phase, await response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/obi_bus.sv
// Minimal OBI bus bundle: address/write phase plus response phase.
interface OBI_BUS;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic [0:0]  a_optional;
    logic        rvalid;
    logic [31:0] rdata;

    modport Manager (
        output req, addr, we, be, wdata, aid, a_optional,
        input  gnt, rvalid, rdata
    );

    modport Subordinate (
        input  req, addr, we, be, wdata, aid, a_optional,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ndma_fifo.sv
// Generic synchronous FIFO, power-of-two depth, registered storage.
// Push is ignored while full, pop is ignored while empty; the head entry
// only changes when it is popped.
module ndma_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = (occ == OCC_W'(DEPTH));
    assign empty_o = (occ == '0);
    assign data_o  = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                occ <= occ + OCC_W'(1);
            end else if (do_pop && !do_push) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/ndma_write_mgr.sv
// NDMA write manager: buffers write jobs from the read stage and issues
// them one at a time as OBI writes, keeping a single transaction in flight.
// Optional macro NDMA_WRITE_MGR_COUNT_EN compiles in a completed-write
// counter on wr_count_o; without it wr_count_o reads 0.
module ndma_write_mgr
    import ndma_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic [3:0]         be_i,
    output logic               ready_o,
    output logic               busy_o,
    input  logic               clear_i,
    output logic [COUNT_W-1:0] wr_count_o,
    OBI_BUS.Manager            write_mgr
);

    wr_state_t state;
    logic      req_q;
    wr_entry_t push_entry;
    wr_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    logic      completion;
    logic      unused_rdata;

    assign push_entry = '{addr: addr_i, wdata: wdata_i, be: be_i};
    assign push       = valid_i && !fifo_full;
    assign pop        = (state == ADDR) && write_mgr.gnt;
    assign completion = (state == RESP) && write_mgr.rvalid;

    ndma_fifo #(
        .T     (wr_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Issue FSM; req is registered alongside the state so it is high exactly in ADDR
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= ADDR;
                        req_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (write_mgr.gnt) begin
                        state <= RESP;
                        req_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (write_mgr.rvalid) begin
                        if (!fifo_empty) begin
                            state <= ADDR;
                            req_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Address phase presents the FIFO head, which is held until popped
    assign write_mgr.req        = req_q;
    assign write_mgr.we         = 1'b1;
    assign write_mgr.addr       = head.addr;
    assign write_mgr.wdata      = head.wdata;
    assign write_mgr.be         = head.be;
    assign write_mgr.aid        = '0;
    assign write_mgr.a_optional = '0;

    // Read data of a write response carries nothing of interest
    assign unused_rdata = ^write_mgr.rdata;

    assign ready_o = !fifo_full;
    assign busy_o  = (state != IDLE) || !fifo_empty;

`ifdef NDMA_WRITE_MGR_COUNT_EN
    logic [COUNT_W-1:0] wr_count_q;

    // Completed-write counter; a completion coinciding with clear counts as the first
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_count_q <= '0;
        end else if (clear_i) begin
            wr_count_q <= completion ? COUNT_W'(1) : '0;
        end else if (completion) begin
            wr_count_q <= wr_count_q + COUNT_W'(1);
        end
    end

    assign wr_count_o = wr_count_q;
`else
    logic unused_clear;
    logic unused_completion;

    assign unused_clear      = clear_i;
    assign unused_completion = completion;
    assign wr_count_o        = '0;
`endif

endmodule

// File: tb/tb_ndma_write_mgr.sv
// Self-checking bench for ndma_write_mgr: directed vector table, directed
// corner sequences, then randomized traffic against a queue-based model.
module tb_ndma_write_mgr;
    import ndma_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 8;
`ifdef NDMA_WRITE_MGR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          ready;
    logic          busy;
    logic          clear;
    logic [CW-1:0] count;

    OBI_BUS obi ();

    ndma_write_mgr #(
        .DEPTH   (DEPTH),
        .COUNT_W (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .ready_o    (ready),
        .busy_o     (busy),
        .clear_i    (clear),
        .wr_count_o (count),
        .write_mgr  (obi.Manager)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        gnt;
        logic        rvalid;
        logic        exp_req;
        logic        exp_ready;
        logic        exp_busy;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t tbl [16];

    // Reference model: pending jobs, address phase pending, response pending
    wr_entry_t   mq [$];
    bit          m_req;
    bit          m_out;
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid      = 1'b0;
        addr       = '0;
        wdata      = '0;
        be         = '0;
        clear      = 1'b0;
        obi.gnt    = 1'b0;
        obi.rvalid = 1'b0;
        obi.rdata  = $urandom();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [CW-1:0] exp_cnt(input int unsigned n);
        return CNT_EN ? CW'(n) : '0;
    endfunction

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (obi.req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(obi.req), 64'(1));
    endtask

    // One job with immediate grant and response; optional clear on the completion cycle
    task automatic run_one(input logic [31:0] a, input logic clr_on_done);
        valid = 1'b1;
        addr  = a;
        wdata = ~a;
        be    = 4'hF;
        tick();
        valid = 1'b0;
        wait_req("one_req");
        obi.gnt = 1'b1;
        tick();
        obi.gnt    = 1'b0;
        obi.rvalid = 1'b1;
        clear      = clr_on_done;
        tick();
        obi.rvalid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic chk_model();
        chk("rnd_req",   64'(obi.req), 64'(m_req));
        chk("rnd_ready", 64'(ready),   64'(mq.size() < DEPTH));
        chk("rnd_busy",  64'(busy),    64'(m_req || m_out || (mq.size() > 0)));
        chk("rnd_count", 64'(count),   64'(exp_cnt(m_cnt)));
        chk("rnd_aid",   64'({obi.aid, obi.a_optional}), 64'(0));
        if (m_req && mq.size() > 0) begin
            chk("rnd_addr",  64'(obi.addr),  64'(mq[0].addr));
            chk("rnd_wdata", 64'(obi.wdata), 64'(mq[0].wdata));
            chk("rnd_be",    64'(obi.be),    64'(mq[0].be));
            chk("rnd_we",    64'(obi.we),    64'(1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        acc;
        bit        done;
        int        pre;
        wr_entry_t e;

        tbl[0]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        tbl[1]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[2]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF};
        tbl[3]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[4]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        tbl[5]  = '{1'b1, 32'h2000, 32'h11111111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        tbl[6]  = '{1'b1, 32'h2004, 32'h22222222, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[7]  = '{1'b1, 32'h2008, 32'h33333333, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h11111111, 4'h1};
        tbl[8]  = '{1'b1, 32'h2008, 32'h33333333, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h11111111, 4'h1};
        tbl[9]  = '{1'b1, 32'h2008, 32'h33333333, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2004, 32'h22222222, 4'h3};
        tbl[12] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[13] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2008, 32'h33333333, 4'hC};
        tbl[14] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0};
        tbl[15] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};

        @(negedge clk);
        do_reset();
        chk("rst_req",   64'(obi.req), 64'(0));
        chk("rst_ready", 64'(ready),   64'(1));
        chk("rst_busy",  64'(busy),    64'(0));
        chk("rst_count", 64'(count),   64'(0));

        // Single job, back-to-back fill, no-gap reissue
        for (int i = 0; i < 16; i++) begin
            valid      = tbl[i].valid;
            addr       = tbl[i].addr;
            wdata      = tbl[i].wdata;
            be         = tbl[i].be;
            obi.gnt    = tbl[i].gnt;
            obi.rvalid = tbl[i].rvalid;
            chk($sformatf("tbl%0d_req", i),   64'(obi.req), 64'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_ready", i), 64'(ready),   64'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_busy", i),  64'(busy),    64'(tbl[i].exp_busy));
            if (tbl[i].exp_req) begin
                chk($sformatf("tbl%0d_addr", i),  64'(obi.addr),  64'(tbl[i].exp_addr));
                chk($sformatf("tbl%0d_wdata", i), 64'(obi.wdata), 64'(tbl[i].exp_wdata));
                chk($sformatf("tbl%0d_be", i),    64'(obi.be),    64'(tbl[i].exp_be));
                chk($sformatf("tbl%0d_we", i),    64'(obi.we),    64'(1));
            end
            tick();
        end
        idle_inputs();
        chk("tbl_count", 64'(count), 64'(exp_cnt(4)));

        // Grant withheld: address phase must hold steady
        valid = 1'b1;
        addr  = 32'hA5A50000;
        wdata = 32'h0BADF00D;
        be    = 4'h6;
        tick();
        idle_inputs();
        wait_req("stall_req_rise");
        for (int k = 0; k < 5; k++) begin
            chk("stall_req",   64'(obi.req),   64'(1));
            chk("stall_addr",  64'(obi.addr),  64'(32'hA5A50000));
            chk("stall_wdata", 64'(obi.wdata), 64'(32'h0BADF00D));
            chk("stall_be",    64'(obi.be),    64'(4'h6));
            chk("stall_ready", 64'(ready),     64'(1));
            tick();
        end
        obi.gnt = 1'b1;
        chk("stall_req_gnt", 64'(obi.req), 64'(1));
        tick();
        obi.gnt = 1'b0;
        chk("stall_req_drop", 64'(obi.req), 64'(0));
        chk("stall_busy_resp", 64'(busy), 64'(1));
        obi.rvalid = 1'b1;
        tick();
        obi.rvalid = 1'b0;
        chk("stall_busy_done", 64'(busy), 64'(0));
        chk("stall_count", 64'(count), 64'(exp_cnt(5)));

        // Reset while a response is outstanding and two jobs are buffered
        valid = 1'b1; addr = 32'h3000; wdata = 32'h1; be = 4'hF;
        tick();
        addr = 32'h3004; wdata = 32'h2;
        tick();
        addr = 32'h3008; wdata = 32'h3; obi.gnt = 1'b1;
        chk("mrst_req",   64'(obi.req), 64'(1));
        chk("mrst_full",  64'(ready),   64'(0));
        tick();
        obi.gnt = 1'b0;
        chk("mrst_ready", 64'(ready),   64'(1));
        tick();
        valid = 1'b0;
        chk("mrst_full2", 64'(ready),   64'(0));
        chk("mrst_busy",  64'(busy),    64'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_req0",   64'(obi.req), 64'(0));
        chk("mrst_busy0",  64'(busy),    64'(0));
        chk("mrst_ready1", 64'(ready),   64'(1));
        chk("mrst_count0", 64'(count),   64'(0));
        obi.rvalid = 1'b1;
        tick();
        obi.rvalid = 1'b0;
        chk("late_rv_count", 64'(count), 64'(0));
        chk("late_rv_busy",  64'(busy),  64'(0));
        tick();
        chk("late_rv_req",   64'(obi.req), 64'(0));

        // Counter clear, wrap and clear-with-completion
        do_reset();
        for (int i = 0; i < 3; i++) run_one(32'h4000 + 32'(i), 1'b0);
        chk("cnt_three", 64'(count), 64'(exp_cnt(3)));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cnt_clear", 64'(count), 64'(0));
        for (int i = 0; i < (1 << CW); i++) begin
            run_one(32'h5000 + 32'(i), 1'b0);
            if (i == (1 << CW) - 2) chk("cnt_max", 64'(count), 64'(exp_cnt((1 << CW) - 1)));
        end
        chk("cnt_wrap", 64'(count), 64'(0));
        run_one(32'h6000, 1'b0);
        run_one(32'h6004, 1'b1);
        chk("cnt_clr_done", 64'(count), 64'(exp_cnt(1)));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cnt_clr_only", 64'(count), 64'(0));

        // Randomized traffic against the queue model
        do_reset();
        mq.delete();
        m_req = 1'b0;
        m_out = 1'b0;
        m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            chk_model();
            rst_n      = ($urandom_range(0, 249) != 0);
            valid      = ($urandom_range(0, 2) != 0);
            addr       = $urandom();
            wdata      = $urandom();
            be         = 4'($urandom());
            obi.gnt    = ($urandom_range(0, 1) != 0);
            obi.rvalid = ($urandom_range(0, 4) < 2);
            obi.rdata  = $urandom();
            clear      = ($urandom_range(0, 39) == 0);
            if (!rst_n) begin
                mq.delete();
                m_req = 1'b0;
                m_out = 1'b0;
                m_cnt = 0;
            end else begin
                pre  = mq.size();
                acc  = valid && (pre < DEPTH);
                done = m_out && obi.rvalid;
                e    = '{addr: addr, wdata: wdata, be: be};
                if (m_req) begin
                    if (obi.gnt) begin
                        void'(mq.pop_front());
                        m_req = 1'b0;
                        m_out = 1'b1;
                    end
                end else if (m_out) begin
                    if (done) begin
                        m_out = 1'b0;
                        m_req = (pre > 0);
                    end
                end else begin
                    m_req = (pre > 0);
                end
                if (done) m_cnt = clear ? 1 : m_cnt + 1;
                else if (clear) m_cnt = 0;
                if (acc) mq.push_back(e);
            end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ndma_write_mgr.md
NDMA_WRITE_MGR -- requirements
Module: ndma_write_mgr

Interface
REQ-001 Parameter: DEPTH, 2, write-buffer entries; power of two, minimum 2.
REQ-002 Parameter: COUNT_W, 16, width of completed-write counter.
REQ-003 Port: clk_i  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_ni  input  1  reset, synchronous, active-low.
REQ-005 Port: valid_i  input  1  write job offered by read stage.
REQ-006 Port: addr_i  input  32  destination word address.
REQ-007 Port: wdata_i  input  32  data word from read stage.
REQ-008 Port: be_i  input  4  byte enables.
REQ-009 Port: ready_o  output  1  buffer can accept a job.
REQ-010 Port: busy_o  output  1  buffered or outstanding write exists.
REQ-011 Port: clear_i  input  1  clear completed-write counter.
REQ-012 Port: wr_count_o  output  COUNT_W  completed writes (only with macro, see REQ-030).
REQ-013 Port: write_mgr  OBI_BUS.Manager  -  OBI manager for destination writes.

Function
REQ-014 Job accepted on cycle where valid_i && ready_o; {addr_i, wdata_i, be_i} pushed into FIFO.
REQ-015 ready_o = FIFO not full; no same-cycle pass-through; valid_i while full ignored, not lost silently from upstream view since ready_o low.
REQ-016 FSM states IDLE, ADDR, RESP; register resets to IDLE.
REQ-017 IDLE: req=0; FIFO non-empty -> ADDR next cycle.
REQ-018 ADDR: req=1, addr/wdata/be = FIFO head, we=1; gnt=1 -> pop head, go RESP; gnt=0 -> stay ADDR, head signals held stable.
REQ-019 RESP: req=0; rvalid=1 -> completion; then FIFO non-empty (pre-push count) -> ADDR, else IDLE; rvalid=0 -> stay RESP.
REQ-020 Exactly one outstanding OBI transaction at any time.
REQ-021 rvalid in IDLE or ADDR ignored.
REQ-022 Latency: job accepted cycle N into empty idle block -> req first high cycle N+2.
REQ-023 Push and pop same cycle permitted; occupancy unchanged; head changes only on pop.
REQ-024 busy_o = (state != IDLE) || FIFO non-empty.
REQ-025 aid, a_optional driven 0; rdata ignored.
REQ-026 FIFO pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-027 rst_ni low at clock edge: state IDLE, FIFO emptied, req 0, ready_o 1, busy_o 0, wr_count_o 0.
REQ-028 Reset mid-transaction discards buffered and outstanding writes; late rvalid after reset ignored per REQ-021.

Configuration
REQ-029 Macro NDMA_WRITE_MGR_COUNT_EN compiles in the completed-write counter.
REQ-030 Defined: wr_count_o increments on each RESP completion, wraps at 2^COUNT_W; clear_i zeroes it; clear_i with simultaneous completion yields 1.
REQ-031 Undefined: counter register absent; wr_count_o tied 0; clear_i unused.

Structure
REQ-032 Package ndma_pkg holds wr_entry_t struct {addr[31:0], wdata[31:0], be[3:0]} and state enum wr_state_t.
REQ-033 FIFO implemented as sub-module ndma_fifo (generic synchronous FIFO, parameterised type and DEPTH), instantiated once.

Verification
REQ-034 Single job addr=0x1000, data=0xDEADBEEF, be=0xF, gnt/rvalid immediate -> req at N+2 with those values, we=1, busy_o low after rvalid, count=1.
REQ-035 gnt held 0 for 5 cycles -> req, addr, wdata, be stable all 5 cycles; pop only on gnt.
REQ-036 Push 3 jobs back-to-back, DEPTH=2, no gnt -> ready_o low after 2 accepted, third held by upstream, accepted after first gnt.
REQ-037 rvalid with FIFO non-empty -> next cycle ADDR, second write issued without IDLE gap.
REQ-038 Reset asserted in RESP with 2 buffered jobs -> next cycle req 0, busy_o 0, ready_o 1; subsequent rvalid no count change.
REQ-039 With macro: 0xFFFF completions then one more -> wr_count_o 0; clear_i with completion -> 1.
